// File: rtl/alu_rr_arbiter_if.sv
// Requester/consumer bundle for the shared-ALU arbiter: per-requester operand
// slices and a valid/ready handshake on the request side, plus one response channel.
interface alu_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_A;
    logic [NUM_REQ*W-1:0] req_B;
    logic [2*NUM_REQ-1:0] req_ALU_control;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [W:0]           resp_C;
    logic                 resp_zero_flag;

    modport master (
        output req_valid, req_A, req_B, req_ALU_control, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_C, resp_zero_flag
    );

    modport slave (
        input  req_valid, req_A, req_B, req_ALU_control, resp_ready,
        output req_ready, resp_valid, resp_id, resp_C, resp_zero_flag
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub/and/or ALU among NUM_REQ requesters;
// one operation in flight, registered W+1-bit result returned over a handshake.
module alu_rr_arbiter #(
    parameter int word_length = 8,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_rr_arbiter_if.slave bus
);
    localparam int W     = word_length;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [1:0]       op_reg;
    logic [ID_W-1:0]  id_reg;
    logic             resp_valid_reg;
    logic [ID_W-1:0]  resp_id_reg;
    logic [W:0]       resp_c_reg;
    logic             resp_zero_reg;

    logic [W-1:0]       a_slice  [NUM_REQ];
    logic [W-1:0]       b_slice  [NUM_REQ];
    logic [1:0]         op_slice [NUM_REQ];
    logic [NUM_REQ-1:0] upper_req;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic [PTR_W-1:0]   ptr_next;
    logic [W:0]         alu_next;

    // upper_req keeps only requests at or above the pointer, so the scan wraps naturally
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_slice[gi]    = bus.req_A[gi*W +: W];
            assign b_slice[gi]    = bus.req_B[gi*W +: W];
            assign op_slice[gi]   = bus.req_ALU_control[2*gi +: 2];
            assign upper_req[gi]  = bus.req_valid[gi] && (PTR_W'(gi) >= ptr_reg);
            assign bus.req_ready[gi] = (state_reg == IDLE) && !rst && grant_any &&
                                       (grant_idx == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_any = |bus.req_valid;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) grant_idx = PTR_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (upper_req[i]) grant_idx = PTR_W'(i);
        end
    end

    assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // Bit W is carry for add and borrow for sub; always 0 for the logic ops
    always_comb begin
        alu_next = '0;
        case (op_reg)
            2'b00:   alu_next = {1'b0, a_reg} + {1'b0, b_reg};
            2'b01:   alu_next = {1'b0, a_reg} - {1'b0, b_reg};
            2'b10:   alu_next = {1'b0, a_reg & b_reg};
            default: alu_next = {1'b0, a_reg | b_reg};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            id_reg         <= '0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_c_reg     <= '0;
            resp_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        a_reg     <= a_slice[grant_idx];
                        b_reg     <= b_slice[grant_idx];
                        op_reg    <= op_slice[grant_idx];
                        id_reg    <= ID_W'(grant_idx);
                        ptr_reg   <= ptr_next;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    resp_c_reg     <= alu_next;
                    resp_zero_reg  <= (alu_next == '0);
                    resp_id_reg    <= id_reg;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid     = resp_valid_reg;
    assign bus.resp_id        = resp_id_reg;
    assign bus.resp_C         = resp_c_reg;
    assign bus.resp_zero_flag = resp_zero_reg;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: transaction-level reference model checked
// every cycle, directed literal cases, then randomized traffic with resets.
module tb_alu_rr_arbiter;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int MOD = 1 << (W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_rr_arbiter_if #(.NUM_REQ(N), .W(W), .ID_W(IDW)) bus ();
    alu_rr_arbiter #(.word_length(W), .NUM_REQ(N), .ID_W(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_ptr = 0;
    int m_busy = 0;     // cycles since accept: 0 free, 1 computing, 2 result offered
    int m_id = 0, m_c = 0, m_z = 0;
    bit m_init = 0;

    function automatic int pick(logic [N-1:0] v, int p);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (v[k] === 1'b1) return k;
        end
        return -1;
    endfunction

    function automatic int alu_ref(int a, int b, int op);
        case (op)
            0:       return a + b;
            1:       return (a - b + MOD) % MOD;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            m_init = 1;
        end else if (m_init) begin
            if (m_busy == 0) begin
                g = pick(bus.req_valid, m_ptr);
                if (g >= 0) begin
                    m_id   = g;
                    m_c    = alu_ref(int'(bus.req_A[g*W +: W]), int'(bus.req_B[g*W +: W]),
                                     int'(bus.req_ALU_control[2*g +: 2]));
                    m_z    = (m_c == 0);
                    m_ptr  = (g + 1) % N;
                    m_busy = 1;
                end
            end else if (m_busy == 1) begin
                m_busy = 2;
            end else if (bus.resp_ready) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        if (m_init) begin
            g = (m_busy == 0 && !rst) ? pick(bus.req_valid, m_ptr) : -1;
            check("req_ready", 32'(bus.req_ready), (g >= 0) ? (1 << g) : 0);
            check("resp_valid", 32'(bus.resp_valid), (m_busy == 2) ? 1 : 0);
            if (m_busy == 2) begin
                check("resp_id", 32'(bus.resp_id), m_id);
                check("resp_C", 32'(bus.resp_C), m_c);
                check("resp_zero", 32'(bus.resp_zero_flag), m_z);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(int k, int a, int b, int op);
        bus.req_valid[k]             = 1'b1;
        bus.req_A[k*W +: W]          = W'(a);
        bus.req_B[k*W +: W]          = W'(b);
        bus.req_ALU_control[2*k +: 2] = 2'(op);
    endtask

    task automatic wait_grant(int k, string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.req_ready[k] !== 1'b1 && t < 20);
        check(name, 32'(bus.req_ready), 1 << k);
    endtask

    task automatic do_op(int k, int a, int b, int op, int exp_c, int exp_z);
        @(posedge clk); #1;
        bus.req_valid = '0;
        set_req(k, a, b, op);
        wait_grant(k, "op_grant");
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("op_exec_no_resp", 32'(bus.resp_valid), 0);
        @(negedge clk);
        check("op_resp_valid", 32'(bus.resp_valid), 1);
        check("op_resp_id", 32'(bus.resp_id), k);
        check("op_resp_C", 32'(bus.resp_C), exp_c);
        check("op_resp_zero", 32'(bus.resp_zero_flag), exp_z);
        $display("op req=%0d A=%0d B=%0d op=%0d -> C=0x%0h zero=%0d", k, a, b, op,
                 bus.resp_C, bus.resp_zero_flag);
    endtask

    initial begin
        int t;
        int glog[$];
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
        logic [W:0] c0;
        logic [N-1:0] xfer;

        bus.req_valid       = '0;
        bus.req_A           = '0;
        bus.req_B           = '0;
        bus.req_ALU_control = '0;
        bus.resp_ready      = 1'b1;

        // reset state, with all valids raised while rst is held
        repeat (2) @(posedge clk);
        #1 bus.req_valid = '1;
        @(negedge clk);
        check("rst_no_grant", 32'(bus.req_ready), 0);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_id", 32'(bus.resp_id), 0);
        check("rst_resp_C", 32'(bus.resp_C), 0);
        check("rst_resp_zero", 32'(bus.resp_zero_flag), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = '0;

        // directed arithmetic with hand-computed results
        do_op(2, 200, 100, 0, 'h12C, 0);
        do_op(0, 5, 5, 1, 'h000, 1);
        do_op(1, 3, 5, 1, 'h1FE, 0);
        do_op(3, 'hF0, 'h0F, 2, 'h000, 1);
        do_op(3, 'hF0, 'h0F, 3, 'h0FF, 0);

        // round robin from a fresh pointer
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 10 * k + 1, k, 0);
        t = 0;
        while (glog.size() < 8 && t < 80) begin
            @(negedge clk);
            t++;
            for (int k = 0; k < N; k++)
                if (bus.req_valid[k] && bus.req_ready[k]) glog.push_back(k);
            if (glog.size() == 6 && bus.req_valid == 4'b1111) begin
                @(posedge clk); #1;
                bus.req_valid = 4'b1010;
            end
        end
        check("rr_grant_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            check("rr_order", glog[i], exp_order[i]);
            $display("rr grant %0d -> req %0d", i, glog[i]);
        end
        bus.req_valid = '0;
        repeat (4) @(posedge clk);

        // backpressure: response held, no grant while waiting
        #1;
        bus.resp_ready = 1'b0;
        set_req(2, 7, 9, 0);
        wait_grant(2, "bp_grant");
        @(posedge clk); #1;
        bus.req_valid = '0;
        set_req(0, 1, 1, 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.resp_valid !== 1'b1 && t < 10);
        check("bp_resp_C", 32'(bus.resp_C), 16);
        c0 = bus.resp_C;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stable_C", 32'(bus.resp_C), 32'(c0));
            check("bp_hold_valid", 32'(bus.resp_valid), 1);
            check("bp_no_grant", 32'(bus.req_ready), 0);
        end
        $display("backpressure held 10 cycles, C=0x%0h", c0);
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.resp_valid), 1);
        @(negedge clk);
        check("bp_regrant", 32'(bus.req_ready), 1);
        check("bp_released", 32'(bus.resp_valid), 0);
        @(posedge clk); #1 bus.req_valid = '0;
        repeat (4) @(posedge clk);

        // reset while an operation is executing
        #1 set_req(3, 9, 4, 1);
        wait_grant(3, "mid_grant");
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_valid = 4'b1010;
        @(negedge clk);
        check("mid_rst_no_resp", 32'(bus.resp_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_lowest", 32'(bus.req_ready), 4'b0010);
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
        $display("reset in EXEC, next grant 0x%0h", bus.req_ready);
        @(posedge clk); #1 bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_idle_no_grant", 32'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = '0;

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            xfer = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (xfer[k] || !bus.req_valid[k]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        set_req(k,
                                ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                                             : int'($urandom_range(0, 255)),
                                ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255)
                                                             : int'($urandom_range(0, 255)),
                                int'($urandom_range(0, 3)));
                    end else begin
                        bus.req_valid[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.req_valid[k] = 1'b0;
                end
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            if (bus.resp_valid && bus.resp_ready && !rst)
                $display("rand resp id=%0d C=0x%0h zero=%0d", bus.resp_id, bus.resp_C,
                         bus.resp_zero_flag);
        end
        rst = 1'b0;
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        repeat (6) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
